// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared state encoding and command-byte layout for the SPI register responder.
package spi_reg_pkg;
  typedef enum logic [2:0] {IDLE, CMD, RD_WAIT, RDATA, WDATA, DONE} state_t;
  localparam int CMD_W = 8;
  localparam int RW_BIT = 7;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with registered-history rise/fall detection.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic s_q;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s_q <= sync_q[STAGES-1];
    end
  end
  assign rise = sync_q[STAGES-1] & ~s_q;
  assign fall = ~sync_q[STAGES-1] & s_q;
endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: oversampled SPI mode-0 responder turning {rw,addr}+data frames into register strobes.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              line_clk,
  input  logic              line_reset,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              si,
  output logic              so,
  output logic              so_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frm_err
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  logic sck_rise, sck_fall, cs_rise, cs_fall, si_s;
  logic [SYNC_STAGES-1:0] si_sync_q, si_sync_d;
  state_t state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CMD_W-2:0] cmd_q, cmd_d;
  logic [CMD_W-1:0] cmd_shift;
  logic [DATA_W-2:0] rx_q, rx_d, tx_q, tx_d;
  logic [DATA_W-1:0] rx_shift;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d, frm_err_q, frm_err_d;
  logic so_q, so_d, so_oe_q, so_oe_d, rd_frame_q, rd_frame_d, err_seen_q, err_seen_d;
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(line_clk), .rst(line_reset), .d(sck), .rise(sck_rise), .fall(sck_fall)
  );
  // Sync flops reset low, so a cs_n held low across reset yields no fall until it has risen.
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(line_clk), .rst(line_reset), .d(cs_n), .rise(cs_rise), .fall(cs_fall)
  );
  assign si_sync_d = {si_sync_q[SYNC_STAGES-2:0], si};
  assign si_s = si_sync_q[SYNC_STAGES-1];
  assign cmd_shift = {cmd_q, si_s};
  assign rx_shift = {rx_q, si_s};
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d = cmd_q;
    rx_d = rx_q;
    tx_d = tx_q;
    so_d = so_q;
    reg_addr_d = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    rd_frame_d = rd_frame_q;
    err_seen_d = err_seen_q;
    reg_wr_d = 1'b0;
    reg_rd_d = 1'b0;
    frm_err_d = 1'b0;
    if (cs_rise && state_q inside {CMD, RD_WAIT, RDATA, WDATA}) begin
      state_d = IDLE;
      frm_err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (cs_fall) begin
          state_d = CMD;
          bit_cnt_d = '0;
          cmd_d = '0;
          rd_frame_d = 1'b0;
          err_seen_d = 1'b0;
        end
        CMD: if (sck_rise) begin
          cmd_d = cmd_shift[CMD_W-2:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
            reg_addr_d = cmd_shift[ADDR_W-1:0];
            bit_cnt_d = '0;
            rd_frame_d = cmd_shift[RW_BIT];
            reg_rd_d = cmd_shift[RW_BIT];
            state_d = cmd_shift[RW_BIT] ? RD_WAIT : WDATA;
          end
        end
        RD_WAIT: if (!reg_rd_q) begin
          tx_d = reg_rdata[DATA_W-2:0];
          so_d = reg_rdata[DATA_W-1];
          state_d = RDATA;
        end
        // The command's last sck fall lands here before any data rise; it must not shift.
        RDATA: if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d = (bit_cnt_q == CNT_W'(DATA_W - 1)) ? DONE : RDATA;
        end else if (sck_fall && bit_cnt_q != '0) begin
          so_d = tx_q[DATA_W-2];
          tx_d = {tx_q[DATA_W-3:0], 1'b0};
        end
        WDATA: if (sck_rise) begin
          rx_d = rx_shift[DATA_W-2:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            reg_wdata_d = rx_shift;
            reg_wr_d = 1'b1;
            state_d = DONE;
          end
        end
        DONE: if (cs_rise) state_d = IDLE;
          else if (sck_rise && !err_seen_q) begin
            frm_err_d = 1'b1;
            err_seen_d = 1'b1;
          end
        default: state_d = IDLE;
      endcase
    end
    so_oe_d = rd_frame_d && (state_d inside {RD_WAIT, RDATA, DONE});
  end
  always_ff @(posedge line_clk or posedge line_reset) begin
    if (line_reset) begin
      si_sync_q <= '0;
      state_q <= IDLE;
      bit_cnt_q <= '0;
      cmd_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      so_q <= 1'b0;
      so_oe_q <= 1'b0;
      reg_addr_q <= '0;
      reg_wdata_q <= '0;
      reg_wr_q <= 1'b0;
      reg_rd_q <= 1'b0;
      frm_err_q <= 1'b0;
      rd_frame_q <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      si_sync_q <= si_sync_d;
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q <= cmd_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      so_q <= so_d;
      so_oe_q <= so_oe_d;
      reg_addr_q <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q <= reg_wr_d;
      reg_rd_q <= reg_rd_d;
      frm_err_q <= frm_err_d;
      rd_frame_q <= rd_frame_d;
      err_seen_q <= err_seen_d;
    end
  end
  assign so = so_q & so_oe_q;
  assign so_oe = so_oe_q;
  assign reg_addr = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr = reg_wr_q;
  assign reg_rd = reg_rd_q;
  assign frm_err = frm_err_q;
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: table-driven SPI master bench for an 8-bit and a 32-bit spi_reg_slave.
module tb_spi_reg_slave;
  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    int nbits;
    int wr;
    int rd;
    int err;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;
  logic clk = 1'b0, line_reset = 1'b1, sck = 1'b0, si = 1'b0;
  logic [1:0] cs_n = 2'b11, so_w, so_oe_w, reg_wr_w, reg_rd_w, frm_err_w;
  logic [6:0] reg_addr0, reg_addr1;
  logic [7:0] reg_wdata0, reg_rdata0 = '0;
  logic [31:0] reg_wdata1, reg_rdata1 = '0;
  logic [7:0] mem0 [128];
  logic [31:0] mem1 [128];
  int wr_cnt [2], rd_cnt [2], err_cnt [2];
  logic [6:0] wr_addr [2], rd_addr [2];
  logic [31:0] wr_data [2];
  int checks = 0, errors = 0;
  vec_t vt [11];
  always #5 clk = ~clk;
  spi_reg_slave #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut0 (
    .line_clk(clk), .line_reset(line_reset), .sck(sck), .cs_n(cs_n[0]), .si(si),
    .so(so_w[0]), .so_oe(so_oe_w[0]), .reg_addr(reg_addr0), .reg_wdata(reg_wdata0),
    .reg_wr(reg_wr_w[0]), .reg_rd(reg_rd_w[0]), .reg_rdata(reg_rdata0), .frm_err(frm_err_w[0])
  );
  spi_reg_slave #(.ADDR_W(7), .DATA_W(32), .SYNC_STAGES(2)) dut1 (
    .line_clk(clk), .line_reset(line_reset), .sck(sck), .cs_n(cs_n[1]), .si(si),
    .so(so_w[1]), .so_oe(so_oe_w[1]), .reg_addr(reg_addr1), .reg_wdata(reg_wdata1),
    .reg_wr(reg_wr_w[1]), .reg_rd(reg_rd_w[1]), .reg_rdata(reg_rdata1), .frm_err(frm_err_w[1])
  );
  always @(negedge clk) begin
    if (reg_wr_w[0]) begin
      wr_cnt[0]++;
      wr_addr[0] = reg_addr0;
      wr_data[0] = {24'h0, reg_wdata0};
      mem0[reg_addr0] = reg_wdata0;
    end
    if (reg_rd_w[0]) begin
      rd_cnt[0]++;
      rd_addr[0] = reg_addr0;
      reg_rdata0 = mem0[reg_addr0];
    end
    if (frm_err_w[0]) err_cnt[0]++;
    if (reg_wr_w[1]) begin
      wr_cnt[1]++;
      wr_addr[1] = reg_addr1;
      wr_data[1] = reg_wdata1;
      mem1[reg_addr1] = reg_wdata1;
    end
    if (reg_rd_w[1]) begin
      rd_cnt[1]++;
      rd_addr[1] = reg_addr1;
      reg_rdata1 = mem1[reg_addr1];
    end
    if (frm_err_w[1]) err_cnt[1]++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      wr_cnt[d] = 0;
      rd_cnt[d] = 0;
      err_cnt[d] = 0;
      wr_addr[d] = '0;
      rd_addr[d] = '0;
      wr_data[d] = '0;
    end
  endtask
  task automatic bit_clk(input int d, input logic b, output logic so_bit, output logic oe_bit);
    si = b;
    #80;
    sck = 1'b1;
    so_bit = so_w[d];
    oe_bit = so_oe_w[d];
    #80;
    sck = 1'b0;
  endtask
  task automatic xfer(input int d, input logic [63:0] fw, input int nbits, input int dw,
                      output logic [31:0] rx, output int oe_bad);
    logic sb, ob;
    rx = '0;
    oe_bad = 0;
    cs_n[d] = 1'b0;
    #160;
    for (int i = 0; i < nbits; i++) begin
      bit_clk(d, fw[63-i], sb, ob);
      if (i >= 8 && i < 8 + dw) rx = {rx[30:0], sb};
      if (ob !== (fw[63] && i >= 8)) oe_bad++;
    end
    #80;
    cs_n[d] = 1'b1;
    #400;
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] rx;
    int oe_bad, oe_hi;
    logic sb, ob;
    for (int a = 0; a < 128; a++) begin
      mem0[a] = '0;
      mem1[a] = '0;
    end
    mem0[5] = 8'h3C;
    clr();
    //        cmd    data  n   wr rd er addr   wdata  rdata
    vt[0]  = '{8'h12, 8'hA5, 16, 1, 0, 0, 7'h12, 8'hA5, 8'h00};
    vt[1]  = '{8'h85, 8'h00, 16, 0, 1, 0, 7'h05, 8'h00, 8'h3C};
    vt[2]  = '{8'h12, 8'h5A, 12, 0, 0, 1, 7'h00, 8'h00, 8'h00};
    vt[3]  = '{8'h92, 8'h00, 16, 0, 1, 0, 7'h12, 8'h00, 8'hA5};
    vt[4]  = '{8'h33, 8'hC3, 20, 1, 0, 1, 7'h33, 8'hC3, 8'h00};
    vt[5]  = '{8'hB3, 8'h00, 16, 0, 1, 0, 7'h33, 8'h00, 8'hC3};
    vt[6]  = '{8'h80, 8'h00, 5,  0, 0, 1, 7'h00, 8'h00, 8'h00};
    vt[7]  = '{8'h85, 8'h00, 12, 0, 1, 1, 7'h05, 8'h00, 8'h00};
    vt[8]  = '{8'h85, 8'h00, 18, 0, 1, 1, 7'h05, 8'h00, 8'h3C};
    vt[9]  = '{8'h7F, 8'h81, 16, 1, 0, 0, 7'h7F, 8'h81, 8'h00};
    vt[10] = '{8'hFF, 8'h00, 16, 0, 1, 0, 7'h7F, 8'h00, 8'h81};
    repeat (5) @(negedge clk);
    chk("rst_strobes", {26'h0, reg_wr_w, reg_rd_w, frm_err_w}, 32'h0);
    line_reset = 1'b0;
    @(negedge clk);
    chk("rst_addr", {25'h0, reg_addr0}, 32'h0);
    chk("rst_wdata", {24'h0, reg_wdata0}, 32'h0);
    chk("rst_so", {28'h0, so_w, so_oe_w}, 32'h0);
    #400;
    for (int i = 0; i < 11; i++) begin
      clr();
      xfer(0, {vt[i].cmd, vt[i].data, 48'hFFFF_FFFF_FFFF}, vt[i].nbits, 8, rx, oe_bad);
      chk($sformatf("v%0d_wr", i), wr_cnt[0], vt[i].wr);
      chk($sformatf("v%0d_rd", i), rd_cnt[0], vt[i].rd);
      chk($sformatf("v%0d_err", i), err_cnt[0], vt[i].err);
      chk($sformatf("v%0d_oe", i), oe_bad, 0);
      if (vt[i].wr > 0) begin
        chk($sformatf("v%0d_waddr", i), {25'h0, wr_addr[0]}, {25'h0, vt[i].addr});
        chk($sformatf("v%0d_wdata", i), wr_data[0], {24'h0, vt[i].wdata});
      end
      if (vt[i].rd > 0) chk($sformatf("v%0d_raddr", i), {25'h0, rd_addr[0]}, {25'h0, vt[i].addr});
      if (vt[i].rd > 0 && vt[i].nbits >= 16) chk($sformatf("v%0d_so", i), rx, {24'h0, vt[i].rdata});
      chk($sformatf("v%0d_idle_oe", i), {30'h0, so_oe_w}, 32'h0);
    end
    clr();
    cs_n[0] = 1'b0;
    #160;
    for (int i = 0; i < 11; i++) bit_clk(0, i < 8 ? 1'((8'h85 >> (7 - i)) & 1) : 1'b0, sb, ob);
    line_reset = 1'b1;
    #20;
    chk("mid_rst_addr", {25'h0, reg_addr0}, 32'h0);
    chk("mid_rst_wdata", {24'h0, reg_wdata0}, 32'h0);
    chk("mid_rst_out", {27'h0, so_w[0], so_oe_w[0], reg_wr_w[0], reg_rd_w[0], frm_err_w[0]}, 32'h0);
    line_reset = 1'b0;
    #20;
    clr();
    oe_hi = 0;
    for (int i = 0; i < 5; i++) begin
      bit_clk(0, 1'b1, sb, ob);
      if (ob !== 1'b0) oe_hi++;
    end
    #80;
    cs_n[0] = 1'b1;
    #400;
    chk("post_rst_strobes", wr_cnt[0] + rd_cnt[0] + err_cnt[0], 0);
    chk("post_rst_oe", oe_hi, 0);
    clr();
    xfer(0, {8'h85, 56'h0}, 16, 8, rx, oe_bad);
    chk("post_rst_rd", rd_cnt[0], 1);
    chk("post_rst_so", rx, 32'h3C);
    chk("post_rst_err", err_cnt[0], 0);
    clr();
    xfer(1, {8'h7F, 32'hDEADBEEF, 24'h0}, 40, 32, rx, oe_bad);
    chk("w32_wr", wr_cnt[1], 1);
    chk("w32_addr", {25'h0, wr_addr[1]}, 32'h7F);
    chk("w32_wdata", wr_data[1], 32'hDEADBEEF);
    chk("w32_err", err_cnt[1], 0);
    chk("w32_dut0_quiet", wr_cnt[0] + rd_cnt[0] + err_cnt[0], 0);
    clr();
    xfer(1, {8'hFF, 56'h0}, 40, 32, rx, oe_bad);
    chk("r32_rd", rd_cnt[1], 1);
    chk("r32_addr", {25'h0, rd_addr[1]}, 32'h7F);
    chk("r32_so", rx, 32'hDEADBEEF);
    chk("r32_oe", oe_bad, 0);
    chk("r32_err", err_cnt[1], 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
